// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default width.
package counter_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/counter_core.sv
// Count register with synchronous load-zero, increment enable and terminal compare.
// Count updates one cycle after clr/en; at_term is combinational from the register.
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/counter_sequencer.sv
// Tick-driven count sequencer: IDLE/RUN/PAUSE/DONE with one-shot or auto-reload runs.
// State and count move one cycle after the deciding inputs; wrap is a same-cycle decode.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             tick,
    input  logic             repeat_mode,
    input  logic [WIDTH-1:0] term,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             irq,
    output logic [1:0]       state
);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [WIDTH-1:0] term_q;
    logic             rep_q;
    logic             cnt_clr;
    logic             cnt_en;
    logic             at_term;
    logic             term_evt;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run parameters are frozen at start so later input changes cannot disturb a run.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            term_q <= '0;
            rep_q  <= 1'b0;
        end else if (state_q == ST_IDLE && start && !stop) begin
            term_q <= term;
            rep_q  <= repeat_mode;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        term_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (!stop && start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (at_term) begin
                        term_evt = 1'b1;
                        cnt_clr  = 1'b1;
                        if (!rep_q) state_d = ST_DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                if (stop || ack) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock   (clock),
        .clear   (clear),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .term    (term_q),
        .count   (count),
        .at_term (at_term)
    );

    assign wrap  = term_evt;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign irq   = (state_q == ST_DONE);
    assign state = state_q;

endmodule
